pcie_cfg_mgmt_bridge: RTL and testbench
=======================================

PCIE_CFG_MGMT_BRIDGE -- requirements
Module: pcie_cfg_mgmt_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: command FIFO entries; power of 2, minimum 2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: ISSUE cycles without done before abort; range 1..65535.
REQ-003 SHALL have parameter STAT_WIDTH, default 16: statistics counter width.
REQ-004 SHALL have port user_clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port user_reset, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port s_axis_cmd_tdata, input, 64: command. [31:0] write data; [41:32] dwaddr; [47:44] byte_en; [48] write (0 = read); [49] wr_readonly; [50] wr_rw1c_as_rw; other bits ignored.
REQ-007 SHALL have port s_axis_cmd_tvalid, input, 1: command valid.
REQ-008 SHALL have port s_axis_cmd_tready, output, 1: high when FIFO not full.
REQ-009 SHALL have port m_axis_rsp_tdata, output, 64: response. [31:0] read data; [41:32] dwaddr echo; [48] write echo; [49] timeout flag; other bits 0.
REQ-010 SHALL have port m_axis_rsp_tvalid, output, 1: response valid.
REQ-011 SHALL have port m_axis_rsp_tready, input, 1: response accepted.
REQ-012 SHALL have port m_axis_rsp_tlast, output, 1: equal to m_axis_rsp_tvalid; every response is one beat.
REQ-013 SHALL have port cfg_mgmt_di, output, 32: write data to core.
REQ-014 SHALL have port cfg_mgmt_do, input, 32: read data from core.
REQ-015 SHALL have port cfg_mgmt_dwaddr, output, 10: DWORD address.
REQ-016 SHALL have port cfg_mgmt_byte_en, output, 4: write byte enables.
REQ-017 SHALL have port cfg_mgmt_rd_en, output, 1: read strobe.
REQ-018 SHALL have port cfg_mgmt_wr_en, output, 1: write strobe.
REQ-019 SHALL have port cfg_mgmt_wr_readonly, output, 1: treat RO bits as RW.
REQ-020 SHALL have port cfg_mgmt_wr_rw1c_as_rw, output, 1: treat RW1C bits as RW.
REQ-021 SHALL have port cfg_mgmt_rd_wr_done, input, 1: core access complete.
REQ-022 SHALL have port stat_cmd_count, output, STAT_WIDTH: responses delivered; wraps.
REQ-023 SHALL have port stat_timeout_count, output, STAT_WIDTH: timed-out accesses; saturates at all-ones.

Function
REQ-024 SHALL push the command into the FIFO on s_axis_cmd_tvalid && s_axis_cmd_tready; s_axis_cmd_tready is registered and low while the FIFO holds FIFO_DEPTH entries.
REQ-025 SHALL keep the occupancy unchanged on a simultaneous push and pop; a push into a full FIFO is impossible because tready is low.
REQ-026 SHALL implement the FSM IDLE -> ISSUE -> RESP -> IDLE; all cfg_mgmt_* and m_axis_rsp_* outputs are registered.
REQ-027 SHALL, in IDLE with a non-empty FIFO, pop the head; next cycle enter ISSUE with dwaddr, di, byte_en, wr_readonly and wr_rw1c_as_rw driven from the popped entry, and rd_en or wr_en set per the write bit.
REQ-028 SHALL hold rd_en/wr_en and all cfg_mgmt_* data steady through ISSUE; only one of rd_en/wr_en is ever high.
REQ-029 SHALL, on cfg_mgmt_rd_wr_done sampled high in ISSUE, capture cfg_mgmt_do (reads) or 0 (writes) and clear the timeout flag; next cycle: strobes low, state RESP, tvalid high.
REQ-030 SHALL count ISSUE cycles from 1; when the count equals TIMEOUT_CYCLES without done, enter RESP with data 0 and the timeout flag set, and increment stat_timeout_count.
REQ-031 SHALL give done priority over timeout when both occur in the same cycle.
REQ-032 SHALL ignore cfg_mgmt_rd_wr_done outside ISSUE.
REQ-033 SHALL hold m_axis_rsp_tdata/tvalid stable in RESP until tready; on the handshake, clear tvalid, increment stat_cmd_count and return to IDLE.
REQ-034 SHALL keep a minimum latency from command handshake to strobe assertion of 2 cycles, and from done to tvalid of 1 cycle.
REQ-035 SHALL process commands strictly in order, one outstanding access at a time.

Reset
REQ-036 SHALL, while user_reset is high, immediately force: FSM IDLE; FIFO empty; s_axis_cmd_tready 0 (1 from the first clock after release); all cfg_mgmt_* outputs 0; m_axis_rsp_tvalid/tlast/tdata 0; stat counters 0. A mid-operation reset drops the in-flight and queued commands with no response.

Verification
REQ-037 SHALL cover: read cmd dwaddr 0x004, core asserts done 3 cycles after rd_en with do=0x00100406 -> rd_en high exactly 3 cycles; response data 0x00100406, addr 0x004, flags 0; stat_cmd_count = 1.
REQ-038 SHALL cover: write cmd dwaddr 0x001, data 0x00000007, byte_en 0x1 -> wr_en high, di/byte_en match, rd_en never high; response data 0, write echo 1.
REQ-039 SHALL cover: TIMEOUT_CYCLES=8 and done never asserted -> strobe high exactly 8 cycles; response timeout flag 1; stat_timeout_count = 1; next queued command proceeds.
REQ-040 SHALL cover: 6 back-to-back commands with FIFO_DEPTH=4 and rsp_tready held low -> tready drops after the FIFO fills; releasing rsp_tready yields 6 responses in order.
REQ-041 SHALL cover: user_reset pulsed mid-ISSUE with 2 commands queued -> strobes drop without a clock edge; no responses; counters 0; a new command after reset completes normally.

Source files
------------

// File: rtl/pcie_cfg_mgmt_bridge.sv
// AXI-Stream to PCIe cfg_mgmt bridge: commands are queued in a small FIFO and replayed
// one at a time on the configuration management port, with a timeout and one-beat responses.
module pcie_cfg_mgmt_bridge #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int STAT_WIDTH     = 16
) (
   input  logic                  user_clk,
   input  logic                  user_reset,
   input  logic [63:0]           s_axis_cmd_tdata,
   input  logic                  s_axis_cmd_tvalid,
   output logic                  s_axis_cmd_tready,
   output logic [63:0]           m_axis_rsp_tdata,
   output logic                  m_axis_rsp_tvalid,
   input  logic                  m_axis_rsp_tready,
   output logic                  m_axis_rsp_tlast,
   output logic [31:0]           cfg_mgmt_di,
   input  logic [31:0]           cfg_mgmt_do,
   output logic [9:0]            cfg_mgmt_dwaddr,
   output logic [3:0]            cfg_mgmt_byte_en,
   output logic                  cfg_mgmt_rd_en,
   output logic                  cfg_mgmt_wr_en,
   output logic                  cfg_mgmt_wr_readonly,
   output logic                  cfg_mgmt_wr_rw1c_as_rw,
   input  logic                  cfg_mgmt_rd_wr_done,
   output logic [STAT_WIDTH-1:0] stat_cmd_count,
   output logic [STAT_WIDTH-1:0] stat_timeout_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
   localparam logic [15:0]   TO_LIMIT   = 16'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   typedef struct packed {
      logic        rw1c;
      logic        ro;
      logic        wr;
      logic [3:0]  be;
      logic [9:0]  addr;
      logic [31:0] data;
   } cmd_t;

   cmd_t            mem [FIFO_DEPTH];
   cmd_t            cmd_in;
   cmd_t            head;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count, count_next;
   state_t          state;
   logic [15:0]     issue_cnt;
   logic            push, pop;
   logic            unused_cmd_bits;

   assign cmd_in = {s_axis_cmd_tdata[50], s_axis_cmd_tdata[49], s_axis_cmd_tdata[48],
                    s_axis_cmd_tdata[47:44], s_axis_cmd_tdata[41:32], s_axis_cmd_tdata[31:0]};
   assign unused_cmd_bits = ^{s_axis_cmd_tdata[63:51], s_axis_cmd_tdata[43:42]};

   assign push = s_axis_cmd_tvalid && s_axis_cmd_tready;
   assign pop  = (state == IDLE) && (count != '0);
   assign head = mem[rd_ptr];
   assign m_axis_rsp_tlast = m_axis_rsp_tvalid;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge user_clk) begin
      if (push) mem[wr_ptr] <= cmd_in;
   end

   always_ff @(posedge user_clk or posedge user_reset) begin
      if (user_reset) begin
         wr_ptr                 <= '0;
         rd_ptr                 <= '0;
         count                  <= '0;
         s_axis_cmd_tready      <= 1'b0;
         state                  <= IDLE;
         issue_cnt              <= '0;
         cfg_mgmt_di            <= '0;
         cfg_mgmt_dwaddr        <= '0;
         cfg_mgmt_byte_en       <= '0;
         cfg_mgmt_rd_en         <= 1'b0;
         cfg_mgmt_wr_en         <= 1'b0;
         cfg_mgmt_wr_readonly   <= 1'b0;
         cfg_mgmt_wr_rw1c_as_rw <= 1'b0;
         m_axis_rsp_tdata       <= '0;
         m_axis_rsp_tvalid      <= 1'b0;
         stat_cmd_count         <= '0;
         stat_timeout_count     <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count             <= count_next;
         s_axis_cmd_tready <= (count_next != FULL_COUNT);

         case (state)
            IDLE: begin
               if (pop) begin
                  state                  <= ISSUE;
                  issue_cnt              <= 16'd1;
                  cfg_mgmt_di            <= head.data;
                  cfg_mgmt_dwaddr        <= head.addr;
                  cfg_mgmt_byte_en       <= head.be;
                  cfg_mgmt_wr_readonly   <= head.ro;
                  cfg_mgmt_wr_rw1c_as_rw <= head.rw1c;
                  cfg_mgmt_rd_en         <= ~head.wr;
                  cfg_mgmt_wr_en         <= head.wr;
               end
            end
            ISSUE: begin
               // done is checked first so it wins over a timeout in the same cycle
               if (cfg_mgmt_rd_wr_done) begin
                  state             <= RESP;
                  cfg_mgmt_rd_en    <= 1'b0;
                  cfg_mgmt_wr_en    <= 1'b0;
                  m_axis_rsp_tvalid <= 1'b1;
                  m_axis_rsp_tdata  <= {14'b0, 1'b0, cfg_mgmt_wr_en, 6'b0, cfg_mgmt_dwaddr,
                                        cfg_mgmt_wr_en ? 32'b0 : cfg_mgmt_do};
               end else if (issue_cnt == TO_LIMIT) begin
                  state             <= RESP;
                  cfg_mgmt_rd_en    <= 1'b0;
                  cfg_mgmt_wr_en    <= 1'b0;
                  m_axis_rsp_tvalid <= 1'b1;
                  m_axis_rsp_tdata  <= {14'b0, 1'b1, cfg_mgmt_wr_en, 6'b0, cfg_mgmt_dwaddr, 32'b0};
                  if (stat_timeout_count != '1) stat_timeout_count <= stat_timeout_count + 1'b1;
               end else begin
                  issue_cnt <= issue_cnt + 1'b1;
               end
            end
            RESP: begin
               if (m_axis_rsp_tready) begin
                  state             <= IDLE;
                  m_axis_rsp_tvalid <= 1'b0;
                  stat_cmd_count    <= stat_cmd_count + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pcie_cfg_mgmt_bridge.sv
// Directed bench for pcie_cfg_mgmt_bridge: a small cfg core model answers accesses and
// every response and status output is compared with hand-computed values.
module tb_pcie_cfg_mgmt_bridge;

   logic        user_clk;
   logic        user_reset;
   logic [63:0] s_axis_cmd_tdata;
   logic        s_axis_cmd_tvalid;
   logic        s_axis_cmd_tready;
   logic [63:0] m_axis_rsp_tdata;
   logic        m_axis_rsp_tvalid;
   logic        m_axis_rsp_tready;
   logic        m_axis_rsp_tlast;
   logic [31:0] cfg_mgmt_di;
   logic [31:0] cfg_mgmt_do;
   logic [9:0]  cfg_mgmt_dwaddr;
   logic [3:0]  cfg_mgmt_byte_en;
   logic        cfg_mgmt_rd_en;
   logic        cfg_mgmt_wr_en;
   logic        cfg_mgmt_wr_readonly;
   logic        cfg_mgmt_wr_rw1c_as_rw;
   logic        cfg_mgmt_rd_wr_done;
   logic [15:0] stat_cmd_count;
   logic [15:0] stat_timeout_count;

   pcie_cfg_mgmt_bridge #(
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (8),
      .STAT_WIDTH     (16)
   ) dut (
      .user_clk               (user_clk),
      .user_reset             (user_reset),
      .s_axis_cmd_tdata       (s_axis_cmd_tdata),
      .s_axis_cmd_tvalid      (s_axis_cmd_tvalid),
      .s_axis_cmd_tready      (s_axis_cmd_tready),
      .m_axis_rsp_tdata       (m_axis_rsp_tdata),
      .m_axis_rsp_tvalid      (m_axis_rsp_tvalid),
      .m_axis_rsp_tready      (m_axis_rsp_tready),
      .m_axis_rsp_tlast       (m_axis_rsp_tlast),
      .cfg_mgmt_di            (cfg_mgmt_di),
      .cfg_mgmt_do            (cfg_mgmt_do),
      .cfg_mgmt_dwaddr        (cfg_mgmt_dwaddr),
      .cfg_mgmt_byte_en       (cfg_mgmt_byte_en),
      .cfg_mgmt_rd_en         (cfg_mgmt_rd_en),
      .cfg_mgmt_wr_en         (cfg_mgmt_wr_en),
      .cfg_mgmt_wr_readonly   (cfg_mgmt_wr_readonly),
      .cfg_mgmt_wr_rw1c_as_rw (cfg_mgmt_wr_rw1c_as_rw),
      .cfg_mgmt_rd_wr_done    (cfg_mgmt_rd_wr_done),
      .stat_cmd_count         (stat_cmd_count),
      .stat_timeout_count     (stat_timeout_count)
   );

   initial user_clk = 1'b0;
   always #5 user_clk = ~user_clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          str_len = 0;
   int          last_len = 0;
   int          lat = 3;
   bit          rd_seen = 0;
   bit          both_seen = 0;
   bit          tlast_bad = 0;
   logic [63:0] rsp_q [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
      end
   endtask

   // Core model: address 0x3FF never completes, others assert done on the lat-th strobe cycle.
   always @(negedge user_clk) begin
      if (cfg_mgmt_rd_en && cfg_mgmt_wr_en) both_seen = 1;
      if (cfg_mgmt_rd_en) rd_seen = 1;
      if (m_axis_rsp_tlast !== m_axis_rsp_tvalid) tlast_bad = 1;
      if (cfg_mgmt_rd_en || cfg_mgmt_wr_en) str_len++;
      else begin
         if (str_len != 0) last_len = str_len;
         str_len = 0;
      end
      cfg_mgmt_do = (cfg_mgmt_dwaddr == 10'h004) ? 32'h0010_0406 : (32'hA500_0000 | 32'(cfg_mgmt_dwaddr));
      cfg_mgmt_rd_wr_done = (cfg_mgmt_rd_en || cfg_mgmt_wr_en) && (cfg_mgmt_dwaddr != 10'h3FF)
                            && (str_len == lat);
      if (m_axis_rsp_tvalid && m_axis_rsp_tready) rsp_q.push_back(m_axis_rsp_tdata);
   end

   task automatic send(input logic [63:0] d);
      int n = 0;
      s_axis_cmd_tdata  = d;
      s_axis_cmd_tvalid = 1'b1;
      @(negedge user_clk);
      while (!s_axis_cmd_tready && n < 100) begin
         @(negedge user_clk);
         n++;
      end
      if (n >= 100) check("cmd_accept_timeout", 64'(s_axis_cmd_tready), 64'd1);
      @(posedge user_clk);
      #1;
      s_axis_cmd_tvalid = 1'b0;
   endtask

   task automatic wait_rsps(input int n);
      int k = 0;
      while (rsp_q.size() < n && k < 300) begin
         @(negedge user_clk);
         k++;
      end
      check("rsp_count", 64'(rsp_q.size()), 64'(n));
   endtask

   task automatic tick();
      @(posedge user_clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      user_reset          = 1'b1;
      s_axis_cmd_tdata    = '0;
      s_axis_cmd_tvalid   = 1'b0;
      m_axis_rsp_tready   = 1'b1;
      cfg_mgmt_do         = '0;
      cfg_mgmt_rd_wr_done = 1'b0;

      // reset state
      repeat (3) @(posedge user_clk);
      @(negedge user_clk);
      check("rst_tready",  64'(s_axis_cmd_tready), 64'd0);
      check("rst_tvalid",  64'(m_axis_rsp_tvalid), 64'd0);
      check("rst_tdata",   m_axis_rsp_tdata, 64'd0);
      check("rst_strobes", 64'({cfg_mgmt_rd_en, cfg_mgmt_wr_en}), 64'd0);
      check("rst_stats",   64'({stat_cmd_count, stat_timeout_count}), 64'd0);
      tick();
      user_reset = 1'b0;
      tick();
      check("tready_after_rst", 64'(s_axis_cmd_tready), 64'd1);

      // read with done on the third strobe cycle
      rsp_q.delete();
      send(64'h0000_0004_0000_0000);
      check("rd_latency_early", 64'(cfg_mgmt_rd_en), 64'd0);
      tick();
      check("rd_en_on", 64'(cfg_mgmt_rd_en), 64'd1);
      check("rd_addr",  64'(cfg_mgmt_dwaddr), 64'h004);
      wait_rsps(1);
      check("rd_rsp",     rsp_q[0], 64'h0000_0004_0010_0406);
      check("rd_str_len", 64'(last_len), 64'd3);
      tick();
      check("rd_stat_cmd", 64'(stat_cmd_count), 64'd1);

      // write
      rsp_q.delete();
      rd_seen = 0;
      send(64'h0001_1001_0000_0007);
      tick();
      check("wr_en_on", 64'(cfg_mgmt_wr_en), 64'd1);
      check("wr_di",    64'(cfg_mgmt_di), 64'h7);
      check("wr_be",    64'(cfg_mgmt_byte_en), 64'h1);
      check("wr_addr",  64'(cfg_mgmt_dwaddr), 64'h001);
      wait_rsps(1);
      check("wr_rsp",     rsp_q[0], 64'h0001_0001_0000_0000);
      check("wr_no_rd",   64'(rd_seen), 64'd0);
      tick();
      check("wr_stat_cmd", 64'(stat_cmd_count), 64'd2);

      // write that times out, followed by a queued read
      rsp_q.delete();
      send(64'h0007_F3FF_DEAD_BEEF);
      tick();
      check("to_flags", 64'({cfg_mgmt_wr_en, cfg_mgmt_wr_readonly, cfg_mgmt_wr_rw1c_as_rw}), 64'h7);
      send(64'h0000_0010_0000_0000);
      wait_rsps(1);
      check("to_rsp",     rsp_q[0], 64'h0003_03FF_0000_0000);
      check("to_str_len", 64'(last_len), 64'd8);
      check("to_stat",    64'(stat_timeout_count), 64'd1);
      wait_rsps(2);
      check("after_to_rsp",     rsp_q[1], 64'h0000_0010_A500_0010);
      check("after_to_str_len", 64'(last_len), 64'd3);
      tick();
      check("after_to_stat_cmd", 64'(stat_cmd_count), 64'd4);
      check("after_to_stat_to",  64'(stat_timeout_count), 64'd1);

      // six back-to-back reads with the response channel stalled
      rsp_q.delete();
      m_axis_rsp_tready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(64'(32'h20 + i) << 32);
         end
         begin
            repeat (20) @(posedge user_clk);
            #1;
            check("bp_tready_low", 64'(s_axis_cmd_tready), 64'd0);
            check("bp_no_rsp",     64'(rsp_q.size()), 64'd0);
            m_axis_rsp_tready = 1'b1;
         end
      join
      wait_rsps(6);
      for (int i = 0; i < 6; i++) begin
         if (rsp_q.size() > i)
            check($sformatf("bp_rsp%0d", i), rsp_q[i],
                  (64'(32'h20 + i) << 32) | 64'(32'hA500_0020 + i));
      end
      tick();
      check("bp_stat_cmd", 64'(stat_cmd_count), 64'd10);

      // reset mid-ISSUE with two commands queued
      rsp_q.delete();
      send(64'h0000_03FF_0000_0000);
      send(64'h0000_0030_0000_0000);
      send(64'h0000_0031_0000_0000);
      check("mid_rd_en", 64'(cfg_mgmt_rd_en), 64'd1);
      #1;
      user_reset = 1'b1;
      #1;
      check("arst_strobes", 64'({cfg_mgmt_rd_en, cfg_mgmt_wr_en}), 64'd0);
      check("arst_tready",  64'(s_axis_cmd_tready), 64'd0);
      check("arst_addr",    64'(cfg_mgmt_dwaddr), 64'd0);
      check("arst_stats",   64'({stat_cmd_count, stat_timeout_count}), 64'd0);
      repeat (2) @(posedge user_clk);
      #1;
      user_reset = 1'b0;
      repeat (12) @(negedge user_clk);
      check("arst_no_rsp", 64'(rsp_q.size()), 64'd0);
      check("arst_idle",   64'({cfg_mgmt_rd_en, cfg_mgmt_wr_en}), 64'd0);
      send(64'h0000_0004_0000_0000);
      wait_rsps(1);
      check("post_rst_rsp", rsp_q[0], 64'h0000_0004_0010_0406);
      tick();
      check("post_rst_stat", 64'({stat_cmd_count, stat_timeout_count}), 64'h0001_0000);

      check("one_hot_strobes", 64'(both_seen), 64'd0);
      check("tlast_eq_tvalid", 64'(tlast_bad), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
